sys_bus_mux: RTL

SYS_BUS_MUX -- requirements
Module: sys_bus_mux

---
 rtl/sys_bus_pkg.sv | 13 +
 rtl/sys_bus_mux_if.sv | 37 +++
 rtl/sys_bus_tmo_cnt.sv | 20 ++
 rtl/sys_bus_mux.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared widths, slot field position, FSM encoding and default timeout for the slot bus mux.
package sys_bus_pkg;
   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int SW       = 4;
   localparam int SLOT_MSB = 22;
   localparam int SLOT_LSB = 20;
   localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;
   localparam int OFS_W    = SLOT_LSB;
   localparam int TMO_DEF  = 255;

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
endpackage

// File: rtl/sys_bus_mux_if.sv
// Master-side request/response and per-slot slave bus; slave modport is the mux, master modport the environment.
interface sys_bus_mux_if
   import sys_bus_pkg::*;
#(
   parameter int NS = 8
);
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_wdata;
   logic [SW-1:0]    m_sel;
   logic             m_wen;
   logic             m_ren;
   logic [DW-1:0]    m_rdata;
   logic             m_err;
   logic             m_ack;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic [SW-1:0]    s_sel;
   logic [NS-1:0]    s_wen;
   logic [NS-1:0]    s_ren;
   logic [NS*DW-1:0] s_rdata;
   logic [NS-1:0]    s_err;
   logic [NS-1:0]    s_ack;

   modport slave (
      input  m_addr, m_wdata, m_sel, m_wen, m_ren,
      output m_rdata, m_err, m_ack,
      output s_addr, s_wdata, s_sel, s_wen, s_ren,
      input  s_rdata, s_err, s_ack
   );

   modport master (
      output m_addr, m_wdata, m_sel, m_wen, m_ren,
      input  m_rdata, m_err, m_ack,
      input  s_addr, s_wdata, s_sel, s_wen, s_ren,
      output s_rdata, s_err, s_ack
   );
endinterface

// File: rtl/sys_bus_tmo_cnt.sv
// 16-bit WAIT-cycle counter: clears on i_clr, counts on i_en, o_tc flags the cycle it reaches TMO.
module sys_bus_tmo_cnt #(
   parameter int TMO = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   logic [15:0] r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + 16'd1;
   end

   assign o_tc = i_en && (r_cnt == 16'(TMO - 1));
endmodule

// File: rtl/sys_bus_mux.sv
// Single-outstanding master-to-slot bus mux; ack at T+3 minimum, out-of-range slot errors at T+2.
// Master strobes outside IDLE are dropped; optional WAIT timeout under SYS_BUS_TIMEOUT_EN.
module sys_bus_mux
   import sys_bus_pkg::*;
#(
   parameter int NS  = 8,
   parameter int TMO = TMO_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   sys_bus_mux_if.slave bus
);
   if (NS < 1 || NS > 8 || TMO < 1 || TMO > 65535) begin : g_param_chk
      $error("sys_bus_mux: NS or TMO out of range");
   end

   state_t              r_state, w_next;
   logic [OFS_W-1:0]    r_addr;
   logic [DW-1:0]       r_wdata;
   logic [SW-1:0]       r_sel;
   logic                r_wr;
   logic [SLOT_W-1:0]   r_slot;
   logic                r_bad;
   logic [DW-1:0]       r_rdata;
   logic                r_err;
   logic                w_req;
   logic [SLOT_W-1:0]   w_slot;
   logic                w_sack;
   logic                w_serr;
   logic [DW-1:0]       w_srdata;
   logic                w_tmo;

   assign w_req  = bus.m_wen | bus.m_ren;
   assign w_slot = bus.m_addr[SLOT_MSB:SLOT_LSB];

   // Only the latched slot's response lane is visible; other slots' acks never reach the FSM.
   always_comb begin
      w_sack   = 1'b0;
      w_serr   = 1'b0;
      w_srdata = '0;
      for (int k = 0; k < NS; k++) begin
         if (r_slot == SLOT_W'(k)) begin
            w_sack   = bus.s_ack[k];
            w_serr   = bus.s_err[k];
            w_srdata = bus.s_rdata[k*DW +: DW];
         end
      end
   end

`ifdef SYS_BUS_TIMEOUT_EN
   sys_bus_tmo_cnt #(.TMO(TMO)) u_tmo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .i_clr (r_state == STROBE),
      .i_en  (r_state == WAIT),
      .o_tc  (w_tmo)
   );
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (w_req) w_next = STROBE;
         STROBE: w_next = r_bad ? RESP : WAIT;
         WAIT:   if (w_sack || w_tmo) w_next = RESP;
         RESP:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
         r_wr    <= 1'b0;
         r_slot  <= '0;
         r_bad   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && w_req) begin
            r_addr  <= bus.m_addr[OFS_W-1:0];
            r_wdata <= bus.m_wdata;
            r_sel   <= bus.m_sel;
            r_wr    <= bus.m_wen;
            r_slot  <= w_slot;
            r_bad   <= int'(w_slot) >= NS;
         end
         if (r_state == STROBE && r_bad) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
         // A slave ack in the terminal-count cycle takes priority over the timeout.
         if (r_state == WAIT) begin
            if (w_sack) begin
               r_rdata <= w_srdata;
               r_err   <= w_serr;
            end else if (w_tmo) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.s_wen = '0;
      bus.s_ren = '0;
      if (r_state == STROBE && !r_bad) begin
         for (int k = 0; k < NS; k++) begin
            if (r_slot == SLOT_W'(k)) begin
               bus.s_wen[k] = r_wr;
               bus.s_ren[k] = !r_wr;
            end
         end
      end
   end

   assign bus.s_addr  = {{(AW-OFS_W){1'b0}}, r_addr};
   assign bus.s_wdata = r_wdata;
   assign bus.s_sel   = r_sel;
   assign bus.m_ack   = (r_state == RESP);
   assign bus.m_err   = (r_state == RESP) && r_err;
   assign bus.m_rdata = r_rdata;
endmodule
